// File: rtl/tp1_alu_pkg.sv
// Shared opcode map and default widths for the tp1_alu datapath ALU.
package tp1_alu_pkg;

  localparam int unsigned LEN_DATO_DEF = 8;
  localparam int unsigned LEN_OP_DEF   = 6;

  // MIPS R-type funct codes
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/tp1_alu_core.sv
// Combinational ALU core: funct-decoded result plus signed overflow for ADD/SUB.
module tp1_alu_core
  import tp1_alu_pkg::*;
#(
  parameter int unsigned LEN_DATO = LEN_DATO_DEF,
  parameter int unsigned LEN_OP   = LEN_OP_DEF
) (
  input  logic [LEN_DATO-1:0] dato_a_i,
  input  logic [LEN_DATO-1:0] dato_b_i,
  input  logic [LEN_OP-1:0]   op_code_i,
  output logic [LEN_DATO-1:0] resultado_o,
  output logic                overflow_o
);

  localparam int unsigned Msb = LEN_DATO - 1;

  logic [LEN_DATO-1:0] sum;
  logic [LEN_DATO-1:0] diff;
  logic                shamt_big;

  assign sum       = dato_a_i + dato_b_i;
  assign diff      = dato_a_i - dato_b_i;
  // Shift amounts at or beyond the width saturate to a full fill
  assign shamt_big = (dato_b_i >= LEN_DATO'(LEN_DATO));

  always_comb begin
    resultado_o = '0;
    overflow_o  = 1'b0;
    case (op_code_i)
      LEN_OP'(OP_ADD): begin
        resultado_o = sum;
        overflow_o  = (dato_a_i[Msb] == dato_b_i[Msb]) && (sum[Msb] != dato_a_i[Msb]);
      end
      LEN_OP'(OP_SUB): begin
        resultado_o = diff;
        overflow_o  = (dato_a_i[Msb] != dato_b_i[Msb]) && (diff[Msb] != dato_a_i[Msb]);
      end
      LEN_OP'(OP_AND): resultado_o = dato_a_i & dato_b_i;
      LEN_OP'(OP_OR):  resultado_o = dato_a_i | dato_b_i;
      LEN_OP'(OP_XOR): resultado_o = dato_a_i ^ dato_b_i;
      LEN_OP'(OP_NOR): resultado_o = ~(dato_a_i | dato_b_i);
      LEN_OP'(OP_SRA): begin
        if (shamt_big) resultado_o = {LEN_DATO{dato_a_i[Msb]}};
        else           resultado_o = $signed(dato_a_i) >>> dato_b_i;
      end
      LEN_OP'(OP_SRL): begin
        if (shamt_big) resultado_o = '0;
        else           resultado_o = dato_a_i >> dato_b_i;
      end
      default: begin
        resultado_o = '0;
        overflow_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/tp1_alu.sv
// ALU top: combinational result plus a registered copy of result, zero and overflow flags.
module tp1_alu
  import tp1_alu_pkg::*;
#(
  parameter int unsigned LEN_DATO = LEN_DATO_DEF,
  parameter int unsigned LEN_OP   = LEN_OP_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [LEN_DATO-1:0] i_dato_a,
  input  logic [LEN_DATO-1:0] i_dato_b,
  input  logic [LEN_OP-1:0]   i_op_code,
  output logic [LEN_DATO-1:0] o_resultado,
  output logic [LEN_DATO-1:0] o_resultado_q,
  output logic                o_zero_q,
  output logic                o_overflow_q
);

  logic [LEN_DATO-1:0] resultado_d, resultado_q;
  logic                zero_d, zero_q;
  logic                overflow_d, overflow_q;

  tp1_alu_core #(
    .LEN_DATO(LEN_DATO),
    .LEN_OP  (LEN_OP)
  ) u_core (
    .dato_a_i   (i_dato_a),
    .dato_b_i   (i_dato_b),
    .op_code_i  (i_op_code),
    .resultado_o(resultado_d),
    .overflow_o (overflow_d)
  );

  assign zero_d = (resultado_d == '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      resultado_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      resultado_q <= resultado_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_resultado   = resultado_d;
  assign o_resultado_q = resultado_q;
  assign o_zero_q      = zero_q;
  assign o_overflow_q  = overflow_q;

endmodule

// File: tb/tb_tp1_alu.sv
// Scoreboard bench for tp1_alu: stimulus queues expectations, a monitor checks after each edge.
module tb_tp1_alu;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       zero;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [5:0] op;
  logic [7:0] res, res_q;
  logic       zero_q, ovf_q;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  tp1_alu #(
    .LEN_DATO(8),
    .LEN_OP  (6)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_dato_a     (a),
    .i_dato_b     (b),
    .i_op_code    (op),
    .o_resultado  (res),
    .o_resultado_q(res_q),
    .o_zero_q     (zero_q),
    .o_overflow_q (ovf_q)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Drive one vector at the falling edge and queue what the next rising edge must capture
  task automatic apply(input string name, input logic [5:0] o, input logic [7:0] va,
                       input logic [7:0] vb, input logic [7:0] r, input logic z,
                       input logic v);
    exp_t e;
    @(negedge clk);
    op = o;
    a  = va;
    b  = vb;
    e.name = name;
    e.res  = r;
    e.zero = z;
    e.ovf  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: inputs are stable from the previous falling edge, so comb and registered agree
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " comb"}, res, e.res);
        check({e.name, " res_q"}, res_q, e.res);
        check({e.name, " zero_q"}, {7'd0, zero_q}, {7'd0, e.zero});
        check({e.name, " ovf_q"}, {7'd0, ovf_q}, {7'd0, e.ovf});
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    op  = OP_ADD;
    a   = 8'h7F;
    b   = 8'h01;
    #1;
    check("reset res_q", res_q, 8'h00);
    check("reset flags", {6'd0, zero_q, ovf_q}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset hold res_q", res_q, 8'h00);
    check("reset comb", res, 8'h80);
    @(negedge clk);
    rst = 1'b0;

    apply("add_ovf",     OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    apply("add_zero",    OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    apply("add_negovf",  OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    apply("sub_neg",     OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    apply("sub_ovf_neg", OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    apply("sub_ovf_pos", OP_SUB, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1);
    apply("and",         OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    apply("or",          OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
    apply("xor",         OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0);
    apply("nor",         OP_NOR, 8'h08, 8'h10, 8'hE7, 1'b0, 1'b0);
    apply("sra_2",       OP_SRA, 8'hA0, 8'h02, 8'hE8, 1'b0, 1'b0);
    apply("srl_1",       OP_SRL, 8'hA0, 8'h01, 8'h50, 1'b0, 1'b0);
    apply("sra_9",       OP_SRA, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b0);
    apply("srl_8",       OP_SRL, 8'h80, 8'h08, 8'h00, 1'b1, 1'b0);
    apply("sra_pos_8",   OP_SRA, 8'h7F, 8'h08, 8'h00, 1'b1, 1'b0);
    apply("srl_7",       OP_SRL, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0);
    apply("sra_0",       OP_SRA, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0);
    apply("undef",       6'h3F,  8'h55, 8'hAA, 8'h00, 1'b1, 1'b0);
    apply("add_plain",   OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    drain();

    // Asynchronous reset between edges with a non-zero registered value
    @(negedge clk);
    #2;
    check("pre-reset res_q", res_q, 8'h46);
    rst = 1'b1;
    #1;
    check("async res_q", res_q, 8'h00);
    check("async flags", {6'd0, zero_q, ovf_q}, 8'h00);
    check("async comb", res, 8'h46);
    op = OP_XOR;
    a  = 8'h0F;
    b  = 8'hF0;
    #1;
    check("reset comb track", res, 8'hFF);
    @(posedge clk);
    #1;
    check("reset edge hold", res_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.name = "post_reset";
      e.res  = 8'hFF;
      e.zero = 1'b0;
      e.ovf  = 1'b0;
      exp_q.push_back(e);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
